// File: rtl/skeleton_bus_arbiter_pkg.sv
// Shared constants, address map and types for the skeleton shared-bus interconnect.
package skeleton_bus_arbiter_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int NUM_SLAVES  = 2;
    localparam int AW          = 16;
    localparam int DW          = 32;

    // Address map: slave 0 is the test RAM, slave 1 the auxiliary peripheral window.
    localparam int TEST_RAM_OFFSET = 4096;
    localparam int TEST_RAM_SIZE   = 256;
    localparam int AUX_OFFSET      = 8192;
    localparam int AUX_SIZE        = 256;

    localparam logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = {AW'(AUX_OFFSET), AW'(TEST_RAM_OFFSET)};
    localparam logic [NUM_SLAVES*AW-1:0] SLAVE_SIZE = {AW'(AUX_SIZE), AW'(TEST_RAM_SIZE)};

    localparam int BUS_TIMEOUT = 255;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} bus_state_t;

    // Width of an index into n items, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skeleton_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after last_grant, wrapping.
module skeleton_rr_arbiter #(
    parameter int NUM_MASTERS = skeleton_bus_arbiter_pkg::NUM_MASTERS,
    localparam int IW = skeleton_bus_arbiter_pkg::idx_w(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          last_grant,
    output logic [IW-1:0]          grant,
    output logic                   valid
);

    import skeleton_bus_arbiter_pkg::*;

    int cand;

    // Scan the masters in rotated order and keep the first one requesting.
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = (int'(last_grant) + k) % NUM_MASTERS;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                grant = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/skeleton_bus_arbiter.sv
// Multi-master, multi-slave shared bus: round-robin grant, window decode,
// unmapped-address error and slave watchdog. All outputs are registered.
module skeleton_bus_arbiter #(
    parameter int NUM_MASTERS = skeleton_bus_arbiter_pkg::NUM_MASTERS,
    parameter int NUM_SLAVES  = skeleton_bus_arbiter_pkg::NUM_SLAVES,
    parameter int AW          = skeleton_bus_arbiter_pkg::AW,
    parameter int DW          = skeleton_bus_arbiter_pkg::DW,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = skeleton_bus_arbiter_pkg::SLAVE_BASE,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_SIZE = skeleton_bus_arbiter_pkg::SLAVE_SIZE,
    parameter int TIMEOUT     = skeleton_bus_arbiter_pkg::BUS_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS-1:0]    m_we,
    input  logic [NUM_MASTERS*AW-1:0] m_addr,
    input  logic [NUM_MASTERS*DW-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic                     m_err,
    output logic [DW-1:0]            m_rdata,
    output logic [NUM_SLAVES-1:0]     s_sel,
    output logic                     s_we,
    output logic [AW-1:0]            s_addr,
    output logic [DW-1:0]            s_wdata,
    input  logic [NUM_SLAVES-1:0]     s_ack,
    input  logic [NUM_SLAVES*DW-1:0]  s_rdata
);

    import skeleton_bus_arbiter_pkg::*;

    localparam int IW = idx_w(NUM_MASTERS);
    localparam int CW = $clog2(TIMEOUT + 1);

    bus_state_t         state;
    logic [IW-1:0]      last_grant;
    logic [IW-1:0]      grant;
    logic [CW-1:0]      cnt;
    logic               err_q;
    logic [DW-1:0]      rdata_q;

    logic [IW-1:0]      arb_grant;
    logic               arb_valid;
    logic               arb_we;
    logic [AW-1:0]      arb_addr;
    logic [DW-1:0]      arb_wdata;
    logic               dec_hit;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic [AW-1:0]      dec_off;
    logic               sel_ack;
    logic [DW-1:0]      sel_rdata;

    skeleton_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
        .req        (m_req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Route the candidate master's transfer fields.
    always_comb begin
        arb_we    = 1'b0;
        arb_addr  = '0;
        arb_wdata = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (arb_grant == IW'(m)) begin
                arb_we    = m_we[m];
                arb_addr  = m_addr[m*AW +: AW];
                arb_wdata = m_wdata[m*DW +: DW];
            end
        end
    end

    // Window decode in AW+1 bits so base+size cannot wrap; lowest index wins on overlap.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        dec_off = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!dec_hit
                && ({1'b0, arb_addr} >= {1'b0, SLAVE_BASE[i*AW +: AW]})
                && ({1'b0, arb_addr} <  ({1'b0, SLAVE_BASE[i*AW +: AW]} + {1'b0, SLAVE_SIZE[i*AW +: AW]}))) begin
                dec_hit    = 1'b1;
                dec_sel[i] = 1'b1;
                dec_off    = arb_addr - SLAVE_BASE[i*AW +: AW];
            end
        end
    end

    // Pick the selected slave's ack and read data; other slaves are ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_sel[i]) begin
                sel_ack   = s_ack[i];
                sel_rdata = s_rdata[i*DW +: DW];
            end
        end
    end

    // Bus FSM with registered master and slave outputs.
    // NOTE: state and outputs use non-blocking assignments, so defaults set at the top (m_ack, m_err) are cleanly overridden later in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_MASTERS - 1);
            grant      <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            m_ack      <= '0;
            m_err      <= 1'b0;
            m_rdata    <= '0;
            s_sel      <= '0;
            s_we       <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
        end else begin
            m_ack <= '0;
            m_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant   <= arb_grant;
                        cnt     <= '0;
                        rdata_q <= '0;
                        if (dec_hit) begin
                            s_sel   <= dec_sel;
                            s_we    <= arb_we;
                            s_addr  <= dec_off;
                            s_wdata <= arb_wdata;
                            state   <= ACCESS;
                        end else begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ack || cnt == CW'(TIMEOUT)) begin
                        // An ack in the timeout cycle still completes cleanly.
                        err_q   <= !sel_ack;
                        rdata_q <= sel_ack ? sel_rdata : '0;
                        s_sel   <= '0;
                        s_we    <= 1'b0;
                        s_addr  <= '0;
                        s_wdata <= '0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    m_ack[grant] <= 1'b1;
                    m_err        <= err_q;
                    m_rdata      <= rdata_q;
                    last_grant   <= grant;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skeleton_bus_arbiter.sv
// Directed bench for skeleton_bus_arbiter with queue-based response and bus scoreboards.
module tb_skeleton_bus_arbiter;

    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        int          master;
        bit          err;
        logic [31:0] rdata;
        bit          chk_rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [1:0]  sel;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM-1:0]     m_req = '0;
    logic [NM-1:0]     m_we = '0;
    logic [NM*AW-1:0]  m_addr = '0;
    logic [NM*DW-1:0]  m_wdata = '0;
    logic [NM-1:0]     m_ack;
    logic              m_err;
    logic [DW-1:0]     m_rdata;
    logic [NS-1:0]     s_sel;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [NS-1:0]     s_ack = '0;
    logic [NS*DW-1:0]  s_rdata;

    logic [31:0] slave_data [NS] = '{32'hDEADBEEF, 32'hCAFEF00D};
    int          slave_wait [NS] = '{0, 0};
    int          wait_cnt   [NS] = '{0, 0};

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    resp_t exp_q[$];
    bus_t  bus_q[$];
    resp_t r;
    bus_t  b;
    logic [NS-1:0] prev_sel = '0;

    assign s_rdata = {slave_data[1], slave_data[0]};

    skeleton_bus_arbiter #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .AW(AW), .DW(DW),
        .SLAVE_BASE({16'h2000, 16'h1000}),
        .SLAVE_SIZE({16'd256, 16'd256}),
        .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model: ack the selected slave after slave_wait[i] cycles; -1 never acks.
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (rst_n && s_sel[i]) begin
                s_ack[i] = (wait_cnt[i] == slave_wait[i]);
                wait_cnt[i]++;
            end else begin
                s_ack[i] = 1'b0;
                wait_cnt[i] = 0;
            end
        end
    end

    // Monitor: compare bus fields on each new select and every master ack against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_sel != '0 && prev_sel == '0) begin
                if (bus_q.size() == 0) check("unexpected_sel", s_sel, 0);
                else begin
                    b = bus_q.pop_front();
                    check("s_sel", s_sel, b.sel);
                    check("s_we", s_we, b.we);
                    check("s_addr", s_addr, b.addr);
                    check("s_wdata", s_wdata, b.wdata);
                end
            end
            if (m_ack != '0) begin
                if (exp_q.size() == 0) check("unexpected_ack", m_ack, 0);
                else begin
                    r = exp_q.pop_front();
                    check("m_ack", m_ack, 64'(1) << r.master);
                    check("m_err", m_err, r.err);
                    check("ack_cycle", cyc, r.cyc);
                    if (r.chk_rdata) check("m_rdata", m_rdata, r.rdata);
                end
            end
        end
        prev_sel = s_sel;
    end

    task automatic set_master(input int m, input bit we, input logic [15:0] addr, input logic [31:0] wdata);
        m_we[m] = we;
        m_addr[m*AW +: AW] = addr;
        m_wdata[m*DW +: DW] = wdata;
    endtask

    task automatic push_resp(input int m, input bit err, input logic [31:0] rd, input bit chk, input int at);
        resp_t e;
        e.master = m; e.err = err; e.rdata = rd; e.chk_rdata = chk; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic push_bus(input logic [1:0] sel, input logic we, input logic [15:0] addr, input logic [31:0] wd);
        bus_t e;
        e.sel = sel; e.we = we; e.addr = addr; e.wdata = wd;
        bus_q.push_back(e);
    endtask

    // Wait (bounded) for m_ack[m]; called at a negedge, returns at the ack negedge.
    task automatic wait_ack(input int m);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_ack[m] && n < 60);
        check("ack_seen", m_ack[m], 1'b1);
    endtask

    task automatic xfer(input int m, input bit we, input logic [15:0] addr, input logic [31:0] wd,
                        input int lat, input bit err, input logic [31:0] rd, input bit chk);
        set_master(m, we, addr, wd);
        m_req[m] = 1'b1;
        push_resp(m, err, rd, chk, cyc + 1 + lat);
        wait_ack(m);
        m_req[m] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_ack"}, m_ack, 0);
        check({tag, "_m_err"}, m_err, 0);
        check({tag, "_m_rdata"}, m_rdata, 0);
        check({tag, "_s_sel"}, s_sel, 0);
        check({tag, "_s_we"}, s_we, 0);
        check({tag, "_s_addr"}, s_addr, 0);
        check({tag, "_s_wdata"}, s_wdata, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int acks;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Master 0 reads 0x1004, slave 0 acks immediately.
        push_bus(2'b01, 1'b0, 16'h0004, 32'h0);
        xfer(0, 1'b0, 16'h1004, 32'h0, 2, 1'b0, 32'hDEADBEEF, 1'b1);

        // Unmapped addresses just below and just above the test RAM window.
        xfer(0, 1'b0, 16'h0FFF, 32'h0, 1, 1'b1, 32'h0, 1'b0);
        xfer(0, 1'b1, 16'h1100, 32'h55, 1, 1'b1, 32'h0, 1'b0);

        // Master 1 writes 0x2010 with 3 slave wait cycles.
        slave_wait[1] = 3;
        push_bus(2'b10, 1'b1, 16'h0010, 32'h12345678);
        xfer(1, 1'b1, 16'h2010, 32'h12345678, 5, 1'b0, 32'hCAFEF00D, 1'b1);
        slave_wait[1] = 0;

        // Both masters request continuously: grants alternate 0,1,0,1 with a 3-cycle period.
        set_master(0, 1'b0, 16'h1008, 32'h0);
        set_master(1, 1'b0, 16'h2020, 32'h0);
        for (int k = 0; k < 4; k++) begin
            push_resp(k % 2, 1'b0, (k % 2 == 0) ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b1, cyc + 3 + 3*k);
            push_bus((k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, (k % 2 == 0) ? 16'h0008 : 16'h0020, 32'h0);
        end
        m_req = 2'b11;
        acks = 0;
        for (int n = 0; n < 60 && acks < 4; n++) begin
            @(negedge clk);
            if (m_ack != '0) acks++;
        end
        m_req = 2'b00;
        check("rr_ack_count", acks, 4);

        // Slave 0 never acks: watchdog error after TIMEOUT+2 cycles with zero data.
        slave_wait[0] = -1;
        push_bus(2'b01, 1'b0, 16'h0000, 32'h0);
        xfer(0, 1'b0, 16'h1000, 32'h0, 10, 1'b1, 32'h0, 1'b1);

        // Reset during ACCESS of a master 1 transfer: outputs clear at once, no ack follows.
        set_master(1, 1'b0, 16'h1010, 32'h0);
        push_bus(2'b01, 1'b0, 16'h0010, 32'h0);
        m_req[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_sel", s_sel, 2'b01);
        rst_n = 1'b0;
        m_req = 2'b00;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // After reset master 0 has first priority even though it was granted last.
        slave_wait[0] = 0;
        set_master(0, 1'b0, 16'h1004, 32'h0);
        set_master(1, 1'b0, 16'h2004, 32'h0);
        push_bus(2'b01, 1'b0, 16'h0004, 32'h0);
        push_resp(0, 1'b0, 32'hDEADBEEF, 1'b1, cyc + 3);
        m_req = 2'b11;
        wait_ack(0);
        m_req = 2'b00;

        repeat (6) @(negedge clk);
        check("resp_queue_empty", exp_q.size(), 0);
        check("bus_queue_empty", bus_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skeleton_bus_arbiter.md
# skeleton_bus_arbiter

Parametrised multi-master, multi-slave shared-bus interconnect for the skeleton design. It replaces the fixed single-master/single-slave address map with:
- round-robin arbitration across `NUM_MASTERS` masters;
- address decoding against per-slave base/size windows;
- an error response for unmapped addresses;
- a watchdog timeout for slaves that never acknowledge.

It sits between the host-side bus masters and peripheral slaves such as the test RAM.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of requesting masters, at least 1.
- `NUM_SLAVES`, 2: number of slave windows, at least 1.
- `AW`, 16: address width.
- `DW`, 32: data width.
- `SLAVE_BASE`, {4096, 8192}: packed `NUM_SLAVES*AW` vector of window base addresses. Slave 0 is the test RAM at offset 4096.
- `SLAVE_SIZE`, {256, 256}: packed `NUM_SLAVES*AW` vector of window sizes in words. A size of 0 disables the window.
- `TIMEOUT`, 255: ACCESS-state cycles allowed before a forced error. Must be at least 1.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset. Asynchronous and active-low.
- `m_req`, in, NUM_MASTERS: per-master request. Held high until that master's `m_ack`.
- `m_we`, in, NUM_MASTERS: 1 = write, 0 = read.
- `m_addr`, in, NUM_MASTERS*AW: absolute address per master.
- `m_wdata`, in, NUM_MASTERS*DW: write data per master.
- `m_ack`, out, NUM_MASTERS: one-cycle completion pulse to the granted master.
- `m_err`, out, 1: qualified by `m_ack`. 1 = unmapped address or timeout.
- `m_rdata`, out, DW: read data, qualified by `m_ack`.
- `s_sel`, out, NUM_SLAVES: one-hot slave select.
- `s_we`, out, 1: write strobe to the selected slave.
- `s_addr`, out, AW: address relative to the selected window, computed as addr − base.
- `s_wdata`, out, DW: write data to the selected slave.
- `s_ack`, in, NUM_SLAVES: slave completion. Sampled only for the selected slave.
- `s_rdata`, in, NUM_SLAVES*DW: read data per slave.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE**
  - If any `m_req` is high, the round-robin arbiter picks the first requester strictly after `last_grant`, wrapping around.
  - Latch the grant index and that master's we, addr and wdata.
  - Decode: slave i hits when base_i ≤ addr < base_i + size_i. The comparison is done in AW+1 bits so the upper bound does not overflow.
  - Overlapping windows: the lowest index wins.
  - Hit: go to ACCESS, with `s_sel` one-hot.
  - Miss: go to RESP with err=1, leaving `s_sel` at 0.
- **ACCESS**
  - `s_sel`, `s_we`, `s_addr` and `s_wdata` are registered and held stable.
  - The timeout counter increments every cycle.
  - `s_ack` of the selected slave: capture `s_rdata` (write transfers capture as well) and go to RESP with err=0.
  - Counter reaches `TIMEOUT` with no ack: drop `s_sel` and go to RESP with err=1 and rdata=0.
  - An ack arriving in the same cycle as the timeout takes priority and completes without error.
- **RESP**
  - Assert `m_ack[grant]` for one cycle with `m_rdata` and `m_err`.
  - Update `last_grant` to the granted master.
  - Return to IDLE.
- Requests raised while the bus is busy wait. There is no preemption.
- A master may keep `m_req` high after its ack to issue the next transfer. It is re-arbitrated with rotated priority.
- `s_ack` from unselected slaves and `m_req` deasserted mid-transfer are ignored. A transfer, once granted, always completes.
- Reset at any time:
  - state returns to IDLE, counter to 0, and `last_grant` to NUM_MASTERS−1 so master 0 has first priority;
  - all outputs go to 0, and `m_rdata` to 0;
  - an in-flight transfer is abandoned and never acked.

## Timing
- The IDLE decision is taken on the edge where `m_req` is sampled high (edge 0).
- Mapped access:
  - `s_sel` is high from edge 1.
  - A slave acking in that same cycle gives RESP after edge 2, so `m_ack` is high in the cycle following edge 2.
  - Minimum latency: 2 cycles from req sample to ack. With N slave wait cycles the latency is 2+N.
- Unmapped access: `m_ack` and `m_err` are high after edge 1 (1-cycle latency).
- Timeout access: `m_ack` with err occurs TIMEOUT+2 cycles after the req sample.
- Back-to-back transfers: the next grant is sampled in the IDLE cycle after RESP. Minimum bus period is 3 cycles per mapped transfer.
- Every output is registered. No combinational path exists from `m_*` or `s_*` inputs to any output.

## Structure
- `Skeleton_package` receives:
  - `NUM_MASTERS`, `NUM_SLAVES`, `AW` and `DW`;
  - the `SLAVE_BASE`/`SLAVE_SIZE` address map, extending the existing `TEST_RAM_OFFSET`/`TEST_RAM_SIZE`;
  - `BUS_TIMEOUT`;
  - the typedef `bus_state_t` enum {IDLE, ACCESS, RESP}.
- One sub-module, `skeleton_rr_arbiter`:
  - inputs: req vector, `last_grant`;
  - outputs: grant index and valid;
  - purely combinational, parametrised by `NUM_MASTERS`.
- Address decode and FSM live in the top module.

## Test plan
- Reset, then master 0 reads 0x1004 with slave 0 acking in the first ACCESS cycle and returning 0xDEADBEEF:
  - `s_sel`=01 and `s_addr`=0x0004;
  - `m_ack[0]` at edge 2 with rdata 0xDEADBEEF and err=0.
- Master 1 writes 0x2010 with data 0x12345678 and slave 1 inserts 3 wait cycles:
  - `s_sel`=10, `s_we`=1, `s_addr`=0x0010, `s_wdata`=0x12345678;
  - `m_ack[1]` 5 cycles after the req sample.
- Master 0 accesses 0x0FFF and, separately, 0x1100: `m_ack[0]` and `m_err`=1 one cycle after the req sample, with `s_sel` never asserted.
- Both masters hold `m_req` high continuously for 4 transfers: grants are 0, 1, 0, 1.
- Slave 0 never acks with TIMEOUT=8: `s_sel` drops, and `m_ack` with err=1 and rdata=0 arrives 10 cycles after the req sample.
- `rst_n` is pulsed low during ACCESS:
  - all outputs are 0 immediately (asynchronously), and no ack is ever issued for that transfer;
  - the next request from master 0 is granted first.
